pulse_generator: RTL and testbench

// - Converts a 1-bit level into single-cycle pulses on its rising edge,

---
 rtl/pulse_generator.sv | 78 +++++++
 tb/tb_pulse_generator.sv | 130 +++++++++++++
 2 files changed

// File: rtl/pulse_generator.sv
// Single-bit edge detector: one-cycle pulses on rising, falling and any edge of level_in.
// Optional macro PULSE_GENERATOR_REGISTERED_OUTPUTS_EN adds one output register stage.
module pulse_generator #(
    parameter logic RESET_LEVEL = 1'b0
) (
    input  logic clock,
    input  logic clear,
    input  logic level_in,
    output logic pulse_posedge_out,
    output logic pulse_negedge_out,
    output logic pulse_anyedge_out
);

    localparam logic [1:0] EDGE_NONE = 2'd0;
    localparam logic [1:0] EDGE_POS  = 2'd1;
    localparam logic [1:0] EDGE_NEG  = 2'd2;

    logic       level_prev_r = RESET_LEVEL;
    logic [1:0] edge_kind_s;
    logic       pos_s;
    logic       neg_s;
    logic       any_s;

    // Track the level seen on the previous clock edge.
    always_ff @(posedge clock) begin
        if (clear) begin
            level_prev_r <= RESET_LEVEL;
        end else begin
            level_prev_r <= level_in;
        end
    end

    // Classify the current cycle; clear forces "no edge" so outputs stay low.
    always_comb begin
        edge_kind_s = EDGE_NONE;
        if (clear) begin
            edge_kind_s = EDGE_NONE;
        end else begin
            case ({level_in, level_prev_r})
                2'b10:   edge_kind_s = EDGE_POS;
                2'b01:   edge_kind_s = EDGE_NEG;
                default: edge_kind_s = EDGE_NONE;
            endcase
        end
    end

    assign pos_s = (edge_kind_s == EDGE_POS);
    assign neg_s = (edge_kind_s == EDGE_NEG);
    assign any_s = pos_s | neg_s;

`ifdef PULSE_GENERATOR_REGISTERED_OUTPUTS_EN
    logic pos_r = 1'b0;
    logic neg_r = 1'b0;
    logic any_r = 1'b0;

    // Register the already-gated terms: one cycle later, same width.
    always_ff @(posedge clock) begin
        if (clear) begin
            pos_r <= 1'b0;
            neg_r <= 1'b0;
            any_r <= 1'b0;
        end else begin
            pos_r <= pos_s;
            neg_r <= neg_s;
            any_r <= any_s;
        end
    end

    assign pulse_posedge_out = pos_r;
    assign pulse_negedge_out = neg_r;
    assign pulse_anyedge_out = any_r;
`else
    assign pulse_posedge_out = pos_s;
    assign pulse_negedge_out = neg_s;
    assign pulse_anyedge_out = any_s;
`endif

endmodule

// File: tb/tb_pulse_generator.sv
// Table-driven bench for pulse_generator (RESET_LEVEL=0 and RESET_LEVEL=1 instances).
// Honours PULSE_GENERATOR_REGISTERED_OUTPUTS_EN by expecting results one cycle later.
module tb_pulse_generator;

`ifdef PULSE_GENERATOR_REGISTERED_OUTPUTS_EN
    localparam bit REG_OUT = 1'b1;
`else
    localparam bit REG_OUT = 1'b0;
`endif

    typedef struct {
        logic       clear;
        logic       level;
        logic [2:0] exp;   // {pos, neg, any} in the cycle the inputs are applied
        string      name;
    } vec_t;

    logic clock = 1'b0;
    logic clear0 = 1'b1, level0 = 1'b0;
    logic clear1 = 1'b1, level1 = 1'b1;
    logic pos0, neg0, any0, pos1, neg1, any1;

    int n_compared = 0;
    int n_mismatched = 0;

    vec_t tab0[$];
    vec_t tab1[$];

    always #5 clock = ~clock;

    pulse_generator #(.RESET_LEVEL(1'b0)) dut0 (
        .clock(clock), .clear(clear0), .level_in(level0),
        .pulse_posedge_out(pos0), .pulse_negedge_out(neg0), .pulse_anyedge_out(any0)
    );

    pulse_generator #(.RESET_LEVEL(1'b1)) dut1 (
        .clock(clock), .clear(clear1), .level_in(level1),
        .pulse_posedge_out(pos1), .pulse_negedge_out(neg1), .pulse_anyedge_out(any1)
    );

    function automatic vec_t mk(input logic c, input logic l, input logic [2:0] e, input string n);
        vec_t v;
        v.clear = c;
        v.level = l;
        v.exp   = e;
        v.name  = n;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [2:0] got, input logic [2:0] want);
        n_compared++;
        if (got !== want) begin
            n_mismatched++;
            $display("FAIL %s[%0d]: pos/neg/any got %b want %b", name, idx, got, want);
        end
    endtask

    task automatic run_table(input int which);
        logic [2:0] prev_exp;
        logic [2:0] want;
        logic [2:0] got;
        int         n;
        vec_t       v;
        prev_exp = 3'b000;
        n = (which == 0) ? tab0.size() : tab1.size();
        for (int i = 0; i < n; i++) begin
            v = (which == 0) ? tab0[i] : tab1[i];
            @(posedge clock);
            #1;
            if (which == 0) begin
                clear0 = v.clear;
                level0 = v.level;
            end else begin
                clear1 = v.clear;
                level1 = v.level;
            end
            #3;
            got  = (which == 0) ? {pos0, neg0, any0} : {pos1, neg1, any1};
            want = REG_OUT ? prev_exp : v.exp;
            check(v.name, i, got, want);
            prev_exp = v.exp;
        end
        // Drain the final registered result.
        if (REG_OUT) begin
            @(posedge clock);
            #1;
            if (which == 0) clear0 = 1'b1; else clear1 = 1'b1;
            #3;
            got = (which == 0) ? {pos0, neg0, any0} : {pos1, neg1, any1};
            check("drain", n, got, prev_exp);
        end
    endtask

    initial begin
        // RESET_LEVEL = 0 instance: reset, rise, fall, toggle, clear mid-edge.
        for (int i = 0; i < 3; i++) tab0.push_back(mk(1'b1, 1'b1, 3'b000, "reset_hold"));
        tab0.push_back(mk(1'b0, 1'b1, 3'b101, "reset_release"));
        tab0.push_back(mk(1'b0, 1'b1, 3'b000, "after_release"));
        tab0.push_back(mk(1'b0, 1'b0, 3'b011, "prep_low"));
        tab0.push_back(mk(1'b0, 1'b0, 3'b000, "low_hold"));
        tab0.push_back(mk(1'b0, 1'b1, 3'b101, "rise"));
        for (int i = 0; i < 4; i++) tab0.push_back(mk(1'b0, 1'b1, 3'b000, "rise_hold"));
        tab0.push_back(mk(1'b0, 1'b0, 3'b011, "fall"));
        for (int i = 0; i < 4; i++) tab0.push_back(mk(1'b0, 1'b0, 3'b000, "fall_hold"));
        for (int i = 0; i < 4; i++) begin
            tab0.push_back(mk(1'b0, 1'b1, 3'b101, "toggle_up"));
            tab0.push_back(mk(1'b0, 1'b0, 3'b011, "toggle_down"));
        end
        tab0.push_back(mk(1'b1, 1'b1, 3'b000, "clear_mid_rise"));
        tab0.push_back(mk(1'b1, 1'b1, 3'b000, "clear_hold"));
        tab0.push_back(mk(1'b0, 1'b1, 3'b101, "release_vs_reset0"));
        tab0.push_back(mk(1'b0, 1'b0, 3'b011, "fall_after_release"));

        // RESET_LEVEL = 1 instance: release compares against 1, clear swallows a rise.
        tab1.push_back(mk(1'b1, 1'b0, 3'b000, "r1_reset"));
        tab1.push_back(mk(1'b1, 1'b0, 3'b000, "r1_reset"));
        tab1.push_back(mk(1'b0, 1'b0, 3'b011, "r1_release_low"));
        tab1.push_back(mk(1'b0, 1'b0, 3'b000, "r1_low_hold"));
        tab1.push_back(mk(1'b1, 1'b1, 3'b000, "r1_clear_mid_rise"));
        for (int i = 0; i < 3; i++) tab1.push_back(mk(1'b0, 1'b1, 3'b000, "r1_no_late_pulse"));
        tab1.push_back(mk(1'b0, 1'b0, 3'b011, "r1_fall"));

        run_table(0);
        run_table(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
